// File: rtl/trapez_shaper_controller_pkg.sv
// trapez_shaper_controller_pkg: shared FSM state type, default widths and peak-timing helper
package trapez_shaper_controller_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 16;
    localparam int DEFAULT_OUTPUT_WIDTH = 32;

    typedef enum logic [1:0] {IDLE, WAIT_PEAK, HOLD} state_e;

    function automatic int peak_samples(input int rise_time, input int flat_top, input int latency);
        return latency + rise_time + flat_top / 2;
    endfunction

endpackage

// File: rtl/trapez_shaper_controller_trigger.sv
// trapez_trigger: fast-difference leading-edge trigger, registered so it lines up with the forwarded sample
module trapez_trigger #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] input_data,
    input  logic                         input_data_valid,
    input  logic        [DATA_WIDTH-1:0] threshold,
    output logic                         trig
);

    logic signed [DATA_WIDTH-1:0] prev_q;
    logic                         prev_valid_q;
    logic                         trig_q;
    logic signed [DATA_WIDTH:0]   diff;
    logic signed [DATA_WIDTH:0]   thr_ext;

    // one extra bit keeps the difference of two signed samples exact
    assign diff    = $signed({input_data[DATA_WIDTH-1], input_data}) - $signed({prev_q[DATA_WIDTH-1], prev_q});
    assign thr_ext = $signed({1'b0, threshold});
    assign trig    = trig_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            trig_q       <= 1'b0;
        end else begin
            trig_q <= input_data_valid && prev_valid_q && (diff > thr_ext);
            if (input_data_valid) begin
                prev_q       <= input_data;
                prev_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/trapez_shaper_controller.sv
// trapez_shaper_controller: trigger, peak timing, pile-up rejection and hold-off around the trapezoidal shaper.
// Optional event/pile-up statistics ports when TRAPEZ_SHAPER_CONTROLLER_STATS_EN is defined.
module trapez_shaper_controller
    import trapez_shaper_controller_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int OUTPUT_WIDTH   = DEFAULT_OUTPUT_WIDTH,
    parameter int RISE_TIME      = 8,
    parameter int FLAT_TOP       = 4,
    parameter int SHAPER_LATENCY = 3,
    parameter int HOLDOFF        = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic signed [DATA_WIDTH-1:0]   input_data,
    input  logic                           input_data_valid,
    input  logic        [DATA_WIDTH-1:0]   threshold,
    output logic signed [DATA_WIDTH-1:0]   shaper_input_data,
    output logic                           shaper_enable,
    input  logic signed [OUTPUT_WIDTH-1:0] shaper_output_data,
    input  logic                           shaper_output_data_valid,
    output logic signed [OUTPUT_WIDTH-1:0] energy,
    output logic                           energy_valid,
    output logic                           pileup,
    output logic                           busy
`ifdef TRAPEZ_SHAPER_CONTROLLER_STATS_EN
    ,
    output logic [31:0]                    event_count,
    output logic [31:0]                    pileup_count
`endif
);

    localparam int PEAK = peak_samples(RISE_TIME, FLAT_TOP, SHAPER_LATENCY);
    localparam int CW   = $clog2(PEAK > HOLDOFF ? PEAK : HOLDOFF) + 1;

    state_e                          state_q;
    logic [CW-1:0]                   cnt_q;
    logic [CW-1:0]                   hcnt_q;
    logic signed [DATA_WIDTH-1:0]    sdata_q;
    logic                            sen_q;
    logic signed [OUTPUT_WIDTH-1:0]  energy_q;
    logic                            energy_valid_q;
    logic                            pileup_q;
    logic                            trig;

    trapez_trigger #(.DATA_WIDTH(DATA_WIDTH)) u_trigger (
        .clk              (clk),
        .reset            (reset),
        .input_data       (input_data),
        .input_data_valid (input_data_valid),
        .threshold        (threshold),
        .trig             (trig)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            hcnt_q         <= '0;
            sdata_q        <= '0;
            sen_q          <= 1'b0;
            energy_q       <= '0;
            energy_valid_q <= 1'b0;
            pileup_q       <= 1'b0;
        end else begin
            sdata_q        <= input_data;
            sen_q          <= input_data_valid;
            energy_valid_q <= 1'b0;
            pileup_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trig) begin
                        state_q <= WAIT_PEAK;
                        cnt_q   <= '0;
                    end
                end
                WAIT_PEAK: begin
                    // a second edge before the peak wins over a coincident peak sample
                    if (trig) begin
                        pileup_q <= 1'b1;
                        state_q  <= HOLD;
                        hcnt_q   <= '0;
                    end else if (shaper_output_data_valid) begin
                        if (cnt_q == CW'(PEAK - 1)) begin
                            energy_q       <= shaper_output_data;
                            energy_valid_q <= 1'b1;
                            state_q        <= HOLD;
                            hcnt_q         <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (trig) begin
                        pileup_q <= 1'b1;
                        hcnt_q   <= '0;
                    end else if (input_data_valid) begin
                        if (hcnt_q == CW'(HOLDOFF - 1)) state_q <= IDLE;
                        else hcnt_q <= hcnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign shaper_input_data = sdata_q;
    assign shaper_enable     = sen_q;
    assign energy            = energy_q;
    assign energy_valid      = energy_valid_q;
    assign pileup            = pileup_q;
    assign busy              = (state_q != IDLE);

`ifdef TRAPEZ_SHAPER_CONTROLLER_STATS_EN
    logic [31:0] event_count_q;
    logic [31:0] pileup_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            event_count_q  <= '0;
            pileup_count_q <= '0;
        end else begin
            if (energy_valid_q && event_count_q != 32'hFFFF_FFFF) event_count_q <= event_count_q + 32'd1;
            if (pileup_q && pileup_count_q != 32'hFFFF_FFFF) pileup_count_q <= pileup_count_q + 32'd1;
        end
    end

    assign event_count  = event_count_q;
    assign pileup_count = pileup_count_q;
`endif

endmodule

// File: tb/tb_trapez_shaper_controller.sv
// tb_trapez_shaper_controller: directed and random stimulus against an event-level reference model
module tb_trapez_shaper_controller;

    localparam int DW = 16;
    localparam int OW = 32;
    localparam int PEAK = 13;
    localparam int HOLDOFF = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic signed [DW-1:0] input_data;
    logic                 input_data_valid;
    logic        [DW-1:0] threshold;
    logic signed [DW-1:0] shaper_input_data;
    logic                 shaper_enable;
    logic signed [OW-1:0] shaper_output_data;
    logic                 shaper_output_data_valid;
    logic signed [OW-1:0] energy;
    logic                 energy_valid;
    logic                 pileup;
    logic                 busy;
`ifdef TRAPEZ_SHAPER_CONTROLLER_STATS_EN
    logic [31:0]          event_count;
    logic [31:0]          pileup_count;
`endif

    trapez_shaper_controller dut (
        .clk                      (clk),
        .reset                    (reset),
        .input_data               (input_data),
        .input_data_valid         (input_data_valid),
        .threshold                (threshold),
        .shaper_input_data        (shaper_input_data),
        .shaper_enable            (shaper_enable),
        .shaper_output_data       (shaper_output_data),
        .shaper_output_data_valid (shaper_output_data_valid),
        .energy                   (energy),
        .energy_valid             (energy_valid),
        .pileup                   (pileup),
        .busy                     (busy)
`ifdef TRAPEZ_SHAPER_CONTROLLER_STATS_EN
        ,
        .event_count              (event_count),
        .pileup_count             (pileup_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model: mode 0 idle, 1 waiting for peak, 2 hold-off; countdowns instead of counters
    int          m_prev;
    bit          m_pv;
    bit          m_trig;
    int          mode;
    int          peak_left;
    int          hold_left;
    int          m_energy;
    bit          m_ev;
    bit          m_pu;
    logic [DW-1:0] m_sid;
    bit          m_sen;
    int          k;
    bit          last_v;

    task automatic step(input bit v, input int d);
        int s;
        int sd;
        bit sv;
        input_data = DW'(d);
        input_data_valid = v;
        sv = last_v;
        shaper_output_data_valid = sv;
        if (sv) k++;
        sd = sv ? 10 * k : 0;
        shaper_output_data = sd;
        @(posedge clk);
        s = int'($signed(input_data));
        if (reset) begin
            m_prev = 0; m_pv = 0; m_trig = 0; mode = 0;
            m_energy = 0; m_ev = 0; m_pu = 0; m_sid = '0; m_sen = 0;
            last_v = 0;
        end else begin
            m_ev = 0;
            m_pu = 0;
            if (mode == 0) begin
                if (m_trig) begin mode = 1; peak_left = PEAK; k = 0; end
            end else if (mode == 1) begin
                if (m_trig) begin m_pu = 1; mode = 2; hold_left = HOLDOFF; end
                else if (sv) begin
                    peak_left--;
                    if (peak_left == 0) begin m_energy = sd; m_ev = 1; mode = 2; hold_left = HOLDOFF; end
                end
            end else begin
                if (m_trig) begin m_pu = 1; hold_left = HOLDOFF; end
                else if (v) begin
                    hold_left--;
                    if (hold_left == 0) mode = 0;
                end
            end
            m_trig = v && m_pv && (s - m_prev > int'(threshold));
            if (v) begin m_prev = s; m_pv = 1; end
            m_sid = input_data;
            m_sen = v;
            last_v = v;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        threshold = 16'd100;
        repeat (3) step(1'b1, 500);
        reset = 1'b0;
        checks++;
        if ({energy_valid, pileup, busy, shaper_enable} !== 4'b0 || energy !== '0 || shaper_input_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ev=%b pu=%b busy=%b en=%b energy=%0d sid=%0d, expected all zero",
                     energy_valid, pileup, busy, shaper_enable, energy, shaper_input_data);
        end
    endtask

    task automatic test_step();
        int n_ev = 0, n_pu = 0, ev_idx = -1;
        threshold = 16'd100;
        repeat (4) step(1'b1, 0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1000);
            checks++;
            if (energy_valid !== m_ev || pileup !== m_pu || busy !== (mode != 0) || energy !== m_energy) begin
                errors++;
                $display("FAIL step_seq i=%0d: got ev=%b pu=%b busy=%b energy=%0d, expected ev=%b pu=%b busy=%b energy=%0d",
                         i, energy_valid, pileup, busy, energy, m_ev, m_pu, mode != 0, m_energy);
            end
            if (energy_valid) begin n_ev++; ev_idx = i; end
            if (pileup) n_pu++;
        end
        checks++;
        if (n_ev !== 1 || ev_idx !== 14) begin
            errors++;
            $display("FAIL step_event: got count=%0d at cycle %0d, expected count=1 at cycle 14", n_ev, ev_idx);
        end
        checks++;
        if (energy !== 130) begin
            errors++;
            $display("FAIL step_energy: got %0d, expected 130", energy);
        end
        checks++;
        if (n_pu !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL step_after: got pileups=%0d busy=%b, expected pileups=0 busy=0", n_pu, busy);
        end
    endtask

    task automatic test_pileup();
        int n_ev = 0, n_pu = 0;
        repeat (3) step(1'b1, 1000);
        for (int i = 0; i < 30; i++) begin
            step(1'b1, i < 6 ? 2000 : 3000);
            checks++;
            if (energy_valid !== m_ev || pileup !== m_pu || busy !== (mode != 0) || energy !== m_energy) begin
                errors++;
                $display("FAIL pileup_seq i=%0d: got ev=%b pu=%b busy=%b energy=%0d, expected ev=%b pu=%b busy=%b energy=%0d",
                         i, energy_valid, pileup, busy, energy, m_ev, m_pu, mode != 0, m_energy);
            end
            if (energy_valid) n_ev++;
            if (pileup) n_pu++;
            if (i == 7) begin
                checks++;
                if (pileup !== 1'b1) begin errors++; $display("FAIL pileup_time: got %b at cycle 7, expected 1", pileup); end
            end
            if (i == 22) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %b at cycle 22, expected 1", busy); end
            end
            if (i == 23) begin
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL hold_release: got %b at cycle 23, expected 0", busy); end
            end
        end
        checks++;
        if (n_pu !== 1 || n_ev !== 0) begin
            errors++;
            $display("FAIL pileup_counts: got pileups=%0d events=%0d, expected 1 and 0", n_pu, n_ev);
        end
    endtask

    task automatic test_slow_ramp();
        int val = 3000;
        bit v;
        for (int i = 0; i < 30; i++) begin
            v = 1'($urandom_range(0, 1));
            if (v) val += 50;
            step(v, val);
            checks++;
            if (busy !== 1'b0 || energy_valid !== 1'b0 || pileup !== 1'b0 || shaper_enable !== v || shaper_input_data !== DW'(val)) begin
                errors++;
                $display("FAIL ramp i=%0d: got busy=%b ev=%b pu=%b en=%b sid=%0d, expected busy=0 ev=0 pu=0 en=%b sid=%0d",
                         i, busy, energy_valid, pileup, shaper_enable, shaper_input_data, v, val);
            end
        end
    endtask

    task automatic test_toggle();
        int n_ev = 0, ev_idx = -1;
        for (int i = 0; i < 6; i++) step(i % 2 == 0, 0);
        for (int i = 0; i < 64; i++) begin
            step(i % 2 == 0, 1000);
            checks++;
            if (energy_valid !== m_ev || pileup !== m_pu || busy !== (mode != 0) || energy !== m_energy) begin
                errors++;
                $display("FAIL toggle_seq i=%0d: got ev=%b pu=%b busy=%b energy=%0d, expected ev=%b pu=%b busy=%b energy=%0d",
                         i, energy_valid, pileup, busy, energy, m_ev, m_pu, mode != 0, m_energy);
            end
            if (energy_valid) begin n_ev++; ev_idx = i; end
        end
        checks++;
        if (n_ev !== 1 || ev_idx !== 27 || energy !== 130) begin
            errors++;
            $display("FAIL toggle_event: got count=%0d cycle=%0d energy=%0d, expected 1, 27, 130", n_ev, ev_idx, energy);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL toggle_hold: got busy=%b, expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int n_ev = 0, n_pu = 0;
        repeat (2) step(1'b1, 0);
        for (int i = 0; i < 26; i++) begin
            reset = (i == 6);
            step(1'b1, 1000);
            reset = 1'b0;
            if (energy_valid) n_ev++;
            if (pileup) n_pu++;
            if (i == 6) begin
                checks++;
                if ({energy_valid, pileup, busy, shaper_enable} !== 4'b0 || energy !== '0 || shaper_input_data !== '0) begin
                    errors++;
                    $display("FAIL mid_reset: got ev=%b pu=%b busy=%b en=%b energy=%0d sid=%0d, expected all zero",
                             energy_valid, pileup, busy, shaper_enable, energy, shaper_input_data);
                end
            end
        end
        checks++;
        if (n_ev !== 0 || n_pu !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_after: got events=%0d pileups=%0d busy=%b, expected 0 0 0", n_ev, n_pu, busy);
        end
    endtask

    task automatic test_random();
        int base = 0;
        int r;
        bit v;
        for (int i = 0; i < 1500; i++) begin
            if (i % 200 == 0) threshold = DW'($urandom_range(50, 600));
            reset = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 19);
            if (r == 0) base += $urandom_range(200, 3000);
            else if (r == 1) base -= $urandom_range(0, 3000);
            else base += int'($urandom_range(0, 40)) - 20;
            if (base > 28000) base = -28000;
            if (base < -28000) base = 0;
            step(v, base);
            reset = 1'b0;
            checks++;
            if (energy_valid !== m_ev || pileup !== m_pu || busy !== (mode != 0) || energy !== m_energy ||
                shaper_enable !== m_sen || shaper_input_data !== m_sid || (energy_valid && pileup)) begin
                errors++;
                $display("FAIL random i=%0d: got ev=%b pu=%b busy=%b energy=%0d en=%b sid=%0d, expected ev=%b pu=%b busy=%b energy=%0d en=%b sid=%0d",
                         i, energy_valid, pileup, busy, energy, shaper_enable, shaper_input_data,
                         m_ev, m_pu, mode != 0, m_energy, m_sen, m_sid);
            end
        end
    endtask

`ifdef TRAPEZ_SHAPER_CONTROLLER_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        repeat (2) step(1'b1, 0);
        reset = 1'b0;
        threshold = 16'd100;
        for (int e = 0; e < 3; e++) begin
            repeat (3) step(1'b1, 0);
            repeat (40) step(1'b1, 1000);
        end
        repeat (3) step(1'b1, 0);
        repeat (6) step(1'b1, 1000);
        repeat (30) step(1'b1, 2000);
        checks++;
        if (event_count !== 32'd3 || pileup_count !== 32'd1) begin
            errors++;
            $display("FAIL stats: got events=%0d pileups=%0d, expected 3 and 1", event_count, pileup_count);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        input_data = '0;
        input_data_valid = 1'b0;
        threshold = '0;
        shaper_output_data = '0;
        shaper_output_data_valid = 1'b0;
        k = 0;
        last_v = 0;
        test_reset();
        test_step();
        test_pileup();
        test_slow_ramp();
        test_toggle();
        test_reset_mid();
        test_random();
`ifdef TRAPEZ_SHAPER_CONTROLLER_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
